spi_slave_ctrl: RTL and testbench

- System-clocked SPI slave controller; successor to the SCLK-clocked lab FSM.
- Synchronises SCLK, CS and MOSI into the `clk` domain and decodes a command word (address plus R/W bit).
- Drives a single-port data memory: read or write, with optional burst auto-increment.
- Sits between the SPI input pins and the data memory; owns MISO and its output enable.

---
 rtl/spi_slave_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_ctrl
// Description : System-clocked SPI (mode 0) slave controller. Synchronises
//               SCLK/CS/MOSI into clk, decodes a command word
//               {addr[ADDR_WIDTH-1:0], rw} and performs single or burst
//               reads/writes on a single-port data memory.
// Ports       : clk, reset (async, active-high)
//               sclk_pin, cs_pin, mosi_pin  - SPI pins from the master
//               miso_pin, miso_en           - slave-out data and pad enable
//               mem_addr, mem_wdata, mem_wren, mem_rden, mem_rdata
//                                           - memory port (1-clk read latency)
//               busy                        - FSM is not idle
//               frame_words                 - words completed this frame (sat.)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_ctrl #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_EN    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk_pin,
    input  logic                  cs_pin,
    input  logic                  mosi_pin,
    output logic                  miso_pin,
    output logic                  miso_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [7:0]            frame_words
);

    // Input shift register must hold either a command word or a data word.
    localparam int c_SHIFT_W = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int c_CNT_W   = $clog2(c_SHIFT_W + 1);
    localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(ADDR_WIDTH);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_FETCH  = 3'd2,
        S_LOAD   = 3'd3,
        S_READ   = 3'd4,
        S_WRITE  = 3'd5,
        S_COMMIT = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    // The newest bit comes straight from mosi_s, so only c_SHIFT_W-1 bits
    // need to be stored between rises.
    logic [c_SHIFT_W-2:0]   r_shift_in;
    logic [DATA_WIDTH-1:0]  r_shift_out;
    logic                   r_miso;
    logic                   r_miso_en;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic                   r_mem_wren;
    logic                   r_mem_rden;
    logic                   r_busy;
    logic [7:0]             r_frame_words;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [c_SHIFT_W-1:0]   w_shift_next;
    logic [7:0]             w_fw_inc;

    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise       = w_sclk_s & ~r_sclk_d;
    assign w_fall       = ~w_sclk_s & r_sclk_d;
    assign w_shift_next = {r_shift_in, w_mosi_s};
    assign w_fw_inc     = (r_frame_words == 8'hFF) ? r_frame_words : r_frame_words + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sclk_sync   <= '0;
            r_cs_sync     <= '1;
            r_mosi_sync   <= '0;
            r_sclk_d      <= 1'b0;
            r_bit_cnt     <= '0;
            r_shift_in    <= '0;
            r_shift_out   <= '0;
            r_miso        <= 1'b0;
            r_miso_en     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wren    <= 1'b0;
            r_mem_rden    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_words <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_pin};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            r_sclk_d    <= w_sclk_s;

            if (w_cs_s) begin
                // Deselect beats everything, including a word-complete rise
                // in the same clk, so a partial/racing write never commits.
                r_state       <= S_IDLE;
                r_miso_en     <= 1'b0;
                r_bit_cnt     <= '0;
                r_frame_words <= '0;
                r_mem_wren    <= 1'b0;
                r_mem_rden    <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_CMD;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end

                    S_CMD: begin
                        if (w_rise) begin
                            r_shift_in <= w_shift_next[c_SHIFT_W-2:0];
                            if (r_bit_cnt == c_CMD_LAST) begin
                                r_bit_cnt  <= '0;
                                r_mem_addr <= w_shift_next[ADDR_WIDTH:1];
                                if (w_shift_next[0]) begin
                                    r_mem_rden <= 1'b1;
                                    r_state    <= S_FETCH;
                                end else begin
                                    r_state    <= S_WRITE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                            end
                        end
                    end

                    S_FETCH: begin
                        // mem_rden was raised on entry; drop it after one clk.
                        r_mem_rden <= 1'b0;
                        r_state    <= S_LOAD;
                    end

                    S_LOAD: begin
                        r_shift_out <= mem_rdata;
                        r_miso      <= mem_rdata[DATA_WIDTH-1];
                        r_miso_en   <= 1'b1;
                        r_state     <= S_READ;
                    end

                    S_READ: begin
                        if (w_rise) begin
                            if (r_bit_cnt == c_DATA_LAST) begin
                                r_bit_cnt     <= '0;
                                r_frame_words <= w_fw_inc;
                                if (BURST_EN != 0) begin
                                    r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                                    r_mem_rden <= 1'b1;
                                    r_state    <= S_FETCH;
                                end else begin
                                    r_miso_en  <= 1'b0;
                                    r_state    <= S_DONE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                            end
                        end else if (w_fall && (r_bit_cnt != '0)) begin
                            // The fall trailing the previous word's last rise
                            // arrives with bit_cnt == 0 and must not shift the
                            // freshly loaded MSB away.
                            r_shift_out <= {r_shift_out[DATA_WIDTH-2:0], 1'b0};
                            r_miso      <= r_shift_out[DATA_WIDTH-2];
                        end
                    end

                    S_WRITE: begin
                        if (w_rise) begin
                            r_shift_in <= w_shift_next[c_SHIFT_W-2:0];
                            if (r_bit_cnt == c_DATA_LAST) begin
                                r_bit_cnt   <= '0;
                                r_mem_wdata <= w_shift_next[DATA_WIDTH-1:0];
                                r_mem_wren  <= 1'b1;
                                r_state     <= S_COMMIT;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                            end
                        end
                    end

                    S_COMMIT: begin
                        // mem_wren is high during this clk with the current
                        // address/data; the address steps only afterwards.
                        r_mem_wren    <= 1'b0;
                        r_frame_words <= w_fw_inc;
                        if (BURST_EN != 0) begin
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                            r_state    <= S_WRITE;
                        end else begin
                            r_state    <= S_DONE;
                        end
                    end

                    S_DONE: begin
                        r_miso_en <= 1'b0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso_pin    = r_miso;
    assign miso_en     = r_miso_en;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wren    = r_mem_wren;
    assign mem_rden    = r_mem_rden;
    assign busy        = r_busy;
    assign frame_words = r_frame_words;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_ctrl
// Description : Directed bench for spi_slave_ctrl. Two instances share SCLK,
//               MOSI and reset: index 0 is built with BURST_EN=0, index 1
//               with BURST_EN=1; each has its own chip select and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk_pin;
    logic       mosi_pin;
    logic [1:0] cs_pin;

    logic       miso_pin    [2];
    logic       miso_en     [2];
    logic [6:0] mem_addr    [2];
    logic [7:0] mem_wdata   [2];
    logic       mem_wren    [2];
    logic       mem_rden    [2];
    logic [7:0] mem_rdata   [2];
    logic       busy        [2];
    logic [7:0] frame_words [2];

    logic [7:0] mem [2][128];

    int         wr_cnt [2] = '{0, 0};
    int         rd_cnt [2] = '{0, 0};
    logic [6:0] wr_addr_log [2][16];
    logic [7:0] wr_data_log [2][16];
    logic [6:0] rd_addr_log [2][16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_slave_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .BURST_EN(0), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin[0]), .mosi_pin(mosi_pin),
        .miso_pin(miso_pin[0]), .miso_en(miso_en[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wren(mem_wren[0]), .mem_rden(mem_rden[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0]), .frame_words(frame_words[0])
    );

    spi_slave_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .BURST_EN(1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin[1]), .mosi_pin(mosi_pin),
        .miso_pin(miso_pin[1]), .miso_en(miso_en[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wren(mem_wren[1]), .mem_rden(mem_rden[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1]), .frame_words(frame_words[1])
    );

    // Memory read port: data valid the clk after mem_rden.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_rden[k]) mem_rdata[k] <= mem[k][mem_addr[k]];
        end
    end

    // Strobe monitor: each strobe is one clk wide, so one negedge sees it.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_wren[k]) begin
                wr_addr_log[k][wr_cnt[k] % 16] <= mem_addr[k];
                wr_data_log[k][wr_cnt[k] % 16] <= mem_wdata[k];
                wr_cnt[k] <= wr_cnt[k] + 1;
            end
            if (mem_rden[k]) begin
                rd_addr_log[k][rd_cnt[k] % 16] <= mem_addr[k];
                rd_cnt[k] <= rd_cnt[k] + 1;
            end
        end
    end

    // Mode-0 master: MOSI set in the low phase, MISO sampled at the rise.
    task automatic spi_xfer(input int d, input int nbits, input logic [31:0] dout,
                            output logic [31:0] din);
        din = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi_pin = dout[i];
            repeat (5) @(negedge clk);
            din      = {din[30:0], miso_pin[d]};
            sclk_pin = 1'b1;
            repeat (5) @(negedge clk);
            sclk_pin = 1'b0;
        end
    endtask

    task automatic cs_low(input int d);
        cs_pin[d] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high(input int d);
        repeat (6) @(negedge clk);
        cs_pin[d] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks += 8;
            if (miso_pin[k] !== 1'b0) begin n_fail++; $display("FAIL reset_miso[%0d] got %b exp 0", k, miso_pin[k]); end
            if (miso_en[k] !== 1'b0) begin n_fail++; $display("FAIL reset_miso_en[%0d] got %b exp 0", k, miso_en[k]); end
            if (mem_wren[k] !== 1'b0) begin n_fail++; $display("FAIL reset_wren[%0d] got %b exp 0", k, mem_wren[k]); end
            if (mem_rden[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rden[%0d] got %b exp 0", k, mem_rden[k]); end
            if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b exp 0", k, busy[k]); end
            if (mem_addr[k] !== 7'h00) begin n_fail++; $display("FAIL reset_addr[%0d] got %h exp 00", k, mem_addr[k]); end
            if (mem_wdata[k] !== 8'h00) begin n_fail++; $display("FAIL reset_wdata[%0d] got %h exp 00", k, mem_wdata[k]); end
            if (frame_words[k] !== 8'h00) begin n_fail++; $display("FAIL reset_fw[%0d] got %0d exp 0", k, frame_words[k]); end
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [31:0] din;
        int w0;
        w0 = wr_cnt[0];
        cs_low(0);
        spi_xfer(0, 8, 32'h24, din);
        spi_xfer(0, 8, 32'h5A, din);
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (frame_words[0] !== 8'd1) begin n_fail++; $display("FAIL sw_fw got %0d exp 1", frame_words[0]); end
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL sw_busy_done got %b exp 1", busy[0]); end
        cs_high(0);
        n_checks += 4;
        if (wr_cnt[0] - w0 !== 1) begin n_fail++; $display("FAIL sw_count got %0d exp 1", wr_cnt[0] - w0); end
        if (wr_addr_log[0][w0 % 16] !== 7'h12) begin n_fail++; $display("FAIL sw_addr got %h exp 12", wr_addr_log[0][w0 % 16]); end
        if (wr_data_log[0][w0 % 16] !== 8'h5A) begin n_fail++; $display("FAIL sw_data got %h exp 5a", wr_data_log[0][w0 % 16]); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL sw_busy_idle got %b exp 0", busy[0]); end
    endtask

    task automatic test_single_read();
        logic [31:0] din;
        int r0;
        mem[0][7'h05] = 8'hC3;
        r0 = rd_cnt[0];
        cs_low(0);
        spi_xfer(0, 8, 32'h0B, din);
        spi_xfer(0, 8, 32'h00, din);
        repeat (4) @(negedge clk);
        n_checks += 5;
        if (din[7:0] !== 8'hC3) begin n_fail++; $display("FAIL sr_miso got %h exp c3", din[7:0]); end
        if (rd_cnt[0] - r0 !== 1) begin n_fail++; $display("FAIL sr_rden_count got %0d exp 1", rd_cnt[0] - r0); end
        if (rd_addr_log[0][r0 % 16] !== 7'h05) begin n_fail++; $display("FAIL sr_addr got %h exp 05", rd_addr_log[0][r0 % 16]); end
        if (miso_en[0] !== 1'b0) begin n_fail++; $display("FAIL sr_miso_en_done got %b exp 0", miso_en[0]); end
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL sr_busy_done got %b exp 1", busy[0]); end
        cs_high(0);
    endtask

    task automatic test_burst_write_wrap();
        logic [31:0] din;
        logic [6:0] exp_a [3];
        logic [7:0] exp_d [3];
        int w0;
        exp_a = '{7'h7F, 7'h00, 7'h01};
        exp_d = '{8'h11, 8'h22, 8'h33};
        w0 = wr_cnt[1];
        cs_low(1);
        spi_xfer(1, 8, 32'hFE, din);
        for (int i = 0; i < 3; i++) spi_xfer(1, 8, {24'h0, exp_d[i]}, din);
        repeat (4) @(negedge clk);
        n_checks += 1;
        if (frame_words[1] !== 8'd3) begin n_fail++; $display("FAIL bw_fw got %0d exp 3", frame_words[1]); end
        cs_high(1);
        n_checks += 2;
        if (wr_cnt[1] - w0 !== 3) begin n_fail++; $display("FAIL bw_count got %0d exp 3", wr_cnt[1] - w0); end
        if (frame_words[1] !== 8'd0) begin n_fail++; $display("FAIL bw_fw_clear got %0d exp 0", frame_words[1]); end
        for (int i = 0; i < 3; i++) begin
            n_checks += 2;
            if (wr_addr_log[1][(w0 + i) % 16] !== exp_a[i]) begin
                n_fail++; $display("FAIL bw_addr%0d got %h exp %h", i, wr_addr_log[1][(w0 + i) % 16], exp_a[i]);
            end
            if (wr_data_log[1][(w0 + i) % 16] !== exp_d[i]) begin
                n_fail++; $display("FAIL bw_data%0d got %h exp %h", i, wr_data_log[1][(w0 + i) % 16], exp_d[i]);
            end
        end
    endtask

    task automatic test_burst_read();
        logic [31:0] din_a;
        logic [31:0] din_b;
        logic [15:0] stream;
        int r0;
        int r_before_last;
        mem[1][7'h10] = 8'hA5;
        mem[1][7'h11] = 8'h3C;
        r0 = rd_cnt[1];
        cs_low(1);
        spi_xfer(1, 8, 32'h21, din_a);
        spi_xfer(1, 15, 32'h0, din_a);
        r_before_last = rd_cnt[1] - r0;
        spi_xfer(1, 1, 32'h0, din_b);
        stream = {din_a[14:0], din_b[0]};
        repeat (4) @(negedge clk);
        n_checks += 5;
        if (stream !== 16'hA53C) begin n_fail++; $display("FAIL br_stream got %h exp a53c", stream); end
        if (r_before_last !== 2) begin n_fail++; $display("FAIL br_rden_count got %0d exp 2", r_before_last); end
        if (rd_addr_log[1][r0 % 16] !== 7'h10) begin n_fail++; $display("FAIL br_addr0 got %h exp 10", rd_addr_log[1][r0 % 16]); end
        if (rd_addr_log[1][(r0 + 1) % 16] !== 7'h11) begin n_fail++; $display("FAIL br_addr1 got %h exp 11", rd_addr_log[1][(r0 + 1) % 16]); end
        if (frame_words[1] !== 8'd2) begin n_fail++; $display("FAIL br_fw got %0d exp 2", frame_words[1]); end
        cs_high(1);
    endtask

    task automatic test_abort();
        logic [31:0] din;
        int w0;
        w0 = wr_cnt[0];
        cs_low(0);
        spi_xfer(0, 8, 32'h24, din);
        spi_xfer(0, 5, 32'h1F, din);
        cs_high(0);
        n_checks += 3;
        if (wr_cnt[0] - w0 !== 0) begin n_fail++; $display("FAIL ab_no_write got %0d exp 0", wr_cnt[0] - w0); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL ab_idle got busy=%b exp 0", busy[0]); end
        if (frame_words[0] !== 8'd0) begin n_fail++; $display("FAIL ab_fw got %0d exp 0", frame_words[0]); end
        cs_low(0);
        spi_xfer(0, 8, 32'h66, din);
        spi_xfer(0, 8, 32'h99, din);
        cs_high(0);
        n_checks += 3;
        if (wr_cnt[0] - w0 !== 1) begin n_fail++; $display("FAIL ab_next_count got %0d exp 1", wr_cnt[0] - w0); end
        if (wr_addr_log[0][w0 % 16] !== 7'h33) begin n_fail++; $display("FAIL ab_next_addr got %h exp 33", wr_addr_log[0][w0 % 16]); end
        if (wr_data_log[0][w0 % 16] !== 8'h99) begin n_fail++; $display("FAIL ab_next_data got %h exp 99", wr_data_log[0][w0 % 16]); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] din;
        int w0;
        int r0;
        mem[0][7'h40] = 8'h5A;
        cs_low(0);
        spi_xfer(0, 8, 32'h81, din);
        spi_xfer(0, 3, 32'h0, din);
        mosi_pin = 1'b0;
        repeat (5) @(negedge clk);
        sclk_pin = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 1;
        if (miso_en[0] !== 1'b1) begin n_fail++; $display("FAIL rr_pre_miso_en got %b exp 1", miso_en[0]); end
        reset = 1'b1;
        #1;
        n_checks += 2;
        if (miso_en[0] !== 1'b0) begin n_fail++; $display("FAIL rr_async_miso_en got %b exp 0", miso_en[0]); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rr_async_busy got %b exp 0", busy[0]); end
        @(negedge clk);
        sclk_pin  = 1'b0;
        cs_pin[0] = 1'b1;
        w0 = wr_cnt[0];
        r0 = rd_cnt[0];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        n_checks += 3;
        if (wr_cnt[0] - w0 !== 0) begin n_fail++; $display("FAIL rr_no_wren got %0d exp 0", wr_cnt[0] - w0); end
        if (rd_cnt[0] - r0 !== 0) begin n_fail++; $display("FAIL rr_no_rden got %0d exp 0", rd_cnt[0] - r0); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy got %b exp 0", busy[0]); end
        cs_low(0);
        spi_xfer(0, 8, 32'h0B, din);
        spi_xfer(0, 8, 32'h00, din);
        cs_high(0);
        n_checks += 1;
        if (din[7:0] !== 8'hC3) begin n_fail++; $display("FAIL rr_next_read got %h exp c3", din[7:0]); end
    endtask

    initial begin
        reset    = 1'b1;
        sclk_pin = 1'b0;
        mosi_pin = 1'b0;
        cs_pin   = 2'b11;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 128; a++) mem[k][a] = 8'h00;
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write_wrap();
        test_burst_read();
        test_abort();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
